fpu_in_multi_chan_sched: RTL and testbench

//  Multi-channel request scheduler in front of one FPU core using the FPU_in

---
 rtl/fpu_in_multi_chan_sched.sv | 183 ++++++++++++++++++
 tb/tb_fpu_in_multi_chan_sched.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_in_multi_chan_sched.sv
// Round-robin scheduler placing NUM_CH buffered request streams onto a single FPU core.
// It routes each result back to the channel that issued it and aborts an op that stalls too long.
module fpu_in_multi_chan_sched #(
   parameter int unsigned FP_WIDTH   = 32,
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_CH-1:0]          req_valid,
   output logic [NUM_CH-1:0]          req_ready,
   input  logic [3*NUM_CH-1:0]        req_op,
   input  logic [2*NUM_CH-1:0]        req_rmode,
   input  logic [FP_WIDTH*NUM_CH-1:0] req_a,
   input  logic [FP_WIDTH*NUM_CH-1:0] req_b,
   output logic [NUM_CH-1:0]          rsp_valid,
   output logic                       rsp_err,
   output logic [FP_WIDTH-1:0]        rsp_result,
   input  logic                       fpu_ready,
   output logic                       fpu_start,
   output logic [2:0]                 fpu_op,
   output logic [1:0]                 fpu_rmode,
   output logic [FP_WIDTH-1:0]        fpu_a,
   output logic [FP_WIDTH-1:0]        fpu_b,
   input  logic [FP_WIDTH-1:0]        fpu_result,
   output logic                       busy,
   output logic                       timeout_err
);
   localparam int unsigned WW = 5 + 2 * FP_WIDTH;
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = $clog2(NUM_CH);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

   logic [WW-1:0]     mem_q  [NUM_CH][FIFO_DEPTH];
   logic [AW-1:0]     wptr_q [NUM_CH];
   logic [AW-1:0]     rptr_q [NUM_CH];
   logic [AW:0]       cnt_q  [NUM_CH];
   logic [WW-1:0]     wdata  [NUM_CH];
   logic [NUM_CH-1:0] push, pop, nonempty;

   state_e              state_q, state_d;
   logic [CW-1:0]       rr_q, rr_d, cur_q, cur_d, gnt_ch;
   logic                gnt_found;
   logic [WW-1:0]       word_q, word_d, head;
   logic                seen_low_q, seen_low_d;
   logic [TW-1:0]       wdog_q, wdog_d;
   logic [NUM_CH-1:0]   rsp_valid_q, rsp_valid_d;
   logic                rsp_err_q, rsp_err_d;
   logic [FP_WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic                terr_q, terr_d;

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         wdata[i]     = {req_op[3*i +: 3], req_rmode[2*i +: 2],
                         req_a[FP_WIDTH*i +: FP_WIDTH], req_b[FP_WIDTH*i +: FP_WIDTH]};
         nonempty[i]  = (cnt_q[i] != '0);
         // Full is judged on the registered count, so a same-cycle pop never frees a slot.
         req_ready[i] = (cnt_q[i] != (AW+1)'(FIFO_DEPTH));
         push[i]      = req_valid[i] & req_ready[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            wptr_q[i] <= '0;
            rptr_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (push[i]) begin
               mem_q[i][wptr_q[i]] <= wdata[i];
               wptr_q[i]           <= wptr_q[i] + 1'b1;
            end
            if (pop[i]) rptr_q[i] <= rptr_q[i] + 1'b1;
            if (push[i] && !pop[i]) cnt_q[i] <= cnt_q[i] + 1'b1;
            else if (!push[i] && pop[i]) cnt_q[i] <= cnt_q[i] - 1'b1;
         end
      end
   end

   // Search starts one past the last granted channel.
   always_comb begin
      int unsigned idx;
      idx       = 0;
      gnt_found = 1'b0;
      gnt_ch    = '0;
      for (int unsigned k = 1; k <= NUM_CH; k++) begin
         idx = (int'(rr_q) + k) % NUM_CH;
         if (!gnt_found && nonempty[CW'(idx)]) begin
            gnt_found = 1'b1;
            gnt_ch    = CW'(idx);
         end
      end
   end

   assign head = mem_q[gnt_ch][rptr_q[gnt_ch]];

   always_comb begin
      state_d      = state_q;
      rr_d         = rr_q;
      cur_d        = cur_q;
      word_d       = word_q;
      seen_low_d   = seen_low_q;
      wdog_d       = wdog_q;
      rsp_valid_d  = '0;
      rsp_err_d    = 1'b0;
      rsp_result_d = '0;
      terr_d       = terr_q;
      pop          = '0;
      unique case (state_q)
         StIdle: begin
            if (fpu_ready && gnt_found) begin
               pop[gnt_ch] = 1'b1;
               word_d      = head;
               cur_d       = gnt_ch;
               rr_d        = gnt_ch;
               state_d     = StIssue;
            end
         end
         StIssue: begin
            seen_low_d = 1'b0;
            wdog_d     = '0;
            state_d    = StWait;
         end
         StWait: begin
            wdog_d = wdog_q + 1'b1;
            if (!fpu_ready) seen_low_d = 1'b1;
            // A ready that never dropped belongs to the previous op, not this one.
            if (fpu_ready && seen_low_q) begin
               rsp_valid_d[cur_q] = 1'b1;
               rsp_result_d       = fpu_result;
               state_d            = StIdle;
            end else if (wdog_d == TW'(TIMEOUT)) begin
               rsp_valid_d[cur_q] = 1'b1;
               rsp_err_d          = 1'b1;
               terr_d             = 1'b1;
               state_d            = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         rr_q         <= CW'(NUM_CH - 1);
         cur_q        <= '0;
         word_q       <= '0;
         seen_low_q   <= 1'b0;
         wdog_q       <= '0;
         rsp_valid_q  <= '0;
         rsp_err_q    <= 1'b0;
         rsp_result_q <= '0;
         terr_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_q         <= rr_d;
         cur_q        <= cur_d;
         word_q       <= word_d;
         seen_low_q   <= seen_low_d;
         wdog_q       <= wdog_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_err_q    <= rsp_err_d;
         rsp_result_q <= rsp_result_d;
         terr_q       <= terr_d;
      end
   end

   assign {fpu_op, fpu_rmode, fpu_a, fpu_b} = word_q;
   assign fpu_start   = (state_q == StIssue);
   assign busy        = (state_q != StIdle) || (|nonempty);
   assign rsp_valid   = rsp_valid_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_result  = rsp_result_q;
   assign timeout_err = terr_q;

endmodule

// File: tb/tb_fpu_in_multi_chan_sched.sv
// Bench for fpu_in_multi_chan_sched: a stub core with programmable latency, plus
// issue and response scoreboards filled in the order grants are expected.
module tb_fpu_in_multi_chan_sched;
   localparam int unsigned TMO = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req_valid, req_ready, rsp_valid;
   logic [11:0]  req_op;
   logic [7:0]   req_rmode;
   logic [127:0] req_a, req_b;
   logic         rsp_err, fpu_ready, fpu_start, busy, timeout_err;
   logic [31:0]  rsp_result, fpu_a, fpu_b, fpu_result;
   logic [2:0]   fpu_op;
   logic [1:0]   fpu_rmode;

   always #5 clk = ~clk;

   fpu_in_multi_chan_sched #(.FP_WIDTH(32), .NUM_CH(4), .FIFO_DEPTH(4), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_rmode(req_rmode), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
      .rsp_err(rsp_err), .rsp_result(rsp_result), .fpu_ready(fpu_ready),
      .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_rmode(fpu_rmode), .fpu_a(fpu_a),
      .fpu_b(fpu_b), .fpu_result(fpu_result), .busy(busy), .timeout_err(timeout_err)
   );

   typedef struct { int ch; logic err; logic [31:0] res; } rsp_t;
   typedef struct { logic [2:0] op; logic [1:0] rm; logic [31:0] a; logic [31:0] b; } iss_t;
   typedef struct {
      int ch; logic [2:0] op; logic [1:0] rm; logic [31:0] a; logic [31:0] b; logic [31:0] res;
   } vec_t;

   rsp_t rsp_q[$];
   iss_t iss_q[$];
   int   checks = 0;
   int   errors = 0;
   int   core_lat = 3;
   logic core_hold = 1'b0;

   // Stub core arithmetic, chosen so 1.0 + 2.0 gives 3.0 in IEEE single.
   function automatic logic [31:0] core_fn(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      return a + b - 32'h3F40_0000 + {29'b0, op};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic load(input int ch, input logic [2:0] op, input logic [1:0] rm,
                       input logic [31:0] a, input logic [31:0] b);
      req_valid[ch]      = 1'b1;
      req_op[3*ch +: 3]  = op;
      req_rmode[2*ch +: 2] = rm;
      req_a[32*ch +: 32] = a;
      req_b[32*ch +: 32] = b;
   endtask

   task automatic expect_op(input int ch, input logic [2:0] op, input logic [1:0] rm,
                            input logic [31:0] a, input logic [31:0] b, input logic do_rsp,
                            input logic err, input logic [31:0] res);
      iss_t i;
      rsp_t r;
      i.op = op; i.rm = rm; i.a = a; i.b = b;
      iss_q.push_back(i);
      if (do_rsp) begin
         r.ch = ch; r.err = err; r.res = res;
         rsp_q.push_back(r);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req_valid = '0;
      @(negedge clk);
      rst = 1'b0;
      rsp_q.delete();
      iss_q.delete();
   endtask

   task automatic drain(input string name, input int budget);
      int   n;
      logic done;
      n = 0;
      while ((rsp_q.size() != 0 || iss_q.size() != 0 || busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      done = (rsp_q.size() == 0 && iss_q.size() == 0 && !busy);
      chk(name, 32'(done), 32'd1);
   endtask

   // Stub core plus response monitor, both sampled on the falling edge.
   initial begin
      logic        core_busy;
      int          cnt;
      logic [2:0]  cop;
      logic [31:0] ca, cb;
      logic [3:0]  prev_v, exp_v;
      iss_t        e;
      rsp_t        r;
      core_busy = 1'b0; cnt = 0; cop = '0; ca = '0; cb = '0; prev_v = '0;
      forever begin
         @(negedge clk);
         if (rsp_valid != '0) begin
            checks++;
            if (rsp_q.size() == 0) begin
               errors++;
               $display("FAIL rsp_unexpected: got valid=%b expected none", rsp_valid);
            end else begin
               r = rsp_q.pop_front();
               exp_v = '0;
               exp_v[r.ch] = 1'b1;
               if (rsp_valid !== exp_v || rsp_err !== r.err || rsp_result !== r.res ||
                   prev_v != '0) begin
                  errors++;
                  $display("FAIL rsp: got valid=%b err=%b res=%h prev=%b expected valid=%b err=%b res=%h prev=0000",
                           rsp_valid, rsp_err, rsp_result, prev_v, exp_v, r.err, r.res);
               end
            end
         end
         prev_v = rsp_valid;
         if (core_busy) begin
            cnt--;
            if (cnt == 0) begin
               fpu_result = core_fn(cop, ca, cb);
               fpu_ready  = 1'b1;
               core_busy  = 1'b0;
            end
         end else if (fpu_start) begin
            checks++;
            if (iss_q.size() == 0) begin
               errors++;
               $display("FAIL issue_unexpected: got op=%h a=%h expected no issue", fpu_op, fpu_a);
            end else begin
               e = iss_q.pop_front();
               if ({fpu_op, fpu_rmode, fpu_a, fpu_b} !== {e.op, e.rm, e.a, e.b}) begin
                  errors++;
                  $display("FAIL issue: got op=%h rm=%h a=%h b=%h expected op=%h rm=%h a=%h b=%h",
                           fpu_op, fpu_rmode, fpu_a, fpu_b, e.op, e.rm, e.a, e.b);
               end
            end
            cop = fpu_op; ca = fpu_a; cb = fpu_b;
            cnt = core_lat;
            core_busy = 1'b1;
            fpu_ready = 1'b0;
         end else begin
            fpu_ready = !core_hold;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t vecs[6];
      int   n;
      logic bad;
      vecs[0] = '{0, 3'd0, 2'd0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
      vecs[1] = '{1, 3'd1, 2'd1, 32'h0000_0010, 32'h0000_0020, 32'hC0C0_0031};
      vecs[2] = '{2, 3'd2, 2'd2, 32'h3F40_0000, 32'h0000_0000, 32'h0000_0002};
      vecs[3] = '{3, 3'd7, 2'd3, 32'hFFFF_FFFF, 32'h3F40_0001, 32'h0000_0007};
      vecs[4] = '{1, 3'd3, 2'd2, 32'h1234_5678, 32'h3F40_0000, 32'h1234_567B};
      vecs[5] = '{0, 3'd4, 2'd1, 32'h8000_0000, 32'hBF40_0000, 32'h0000_0004};

      rst = 1'b1; req_valid = '0; req_op = '0; req_rmode = '0; req_a = '0; req_b = '0;
      fpu_ready = 1'b1; fpu_result = '0;
      repeat (2) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'hF);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_fpu_start", 32'(fpu_start), 32'h0);
      chk("rst_timeout_err", 32'(timeout_err), 32'h0);
      chk("rst_fpu_a", fpu_a, 32'h0);
      rst = 1'b0;

      // Single request: issue latency and response latency.
      core_lat = 5;
      @(negedge clk);
      load(0, 3'd0, 2'd0, 32'h3F80_0000, 32'h4000_0000);
      expect_op(0, 3'd0, 2'd0, 32'h3F80_0000, 32'h4000_0000, 1'b1, 1'b0, 32'h4040_0000);
      @(negedge clk);
      req_valid = '0;
      chk("t1_start_T1", 32'(fpu_start), 32'h0);
      chk("t1_busy", 32'(busy), 32'h1);
      @(negedge clk);
      chk("t1_start_T2", 32'(fpu_start), 32'h1);
      n = 0;
      while (rsp_valid == '0 && n < 40) begin
         @(negedge clk);
         n++;
         if (n == 1) chk("t1_start_pulse", 32'(fpu_start), 32'h0);
      end
      chk("t1_rsp_latency", 32'(n), 32'd6);
      drain("t1_drain", 50);

      // Same-cycle pushes from all channels, then rr continuation after ch3.
      do_reset();
      core_lat = 3;
      for (int c = 0; c < 4; c++) begin
         load(c, 3'(c + 1), 2'(c), 32'h100 * (c + 1), 32'h3F40_0000);
         expect_op(c, 3'(c + 1), 2'(c), 32'h100 * (c + 1), 32'h3F40_0000, 1'b1, 1'b0,
                   core_fn(3'(c + 1), 32'h100 * (c + 1), 32'h3F40_0000));
      end
      @(negedge clk);
      req_valid = '0;
      drain("t2_all_drain", 200);
      load(2, 3'd5, 2'd1, 32'h2222_0000, 32'h3F40_0000);
      load(0, 3'd6, 2'd2, 32'h0000_1111, 32'h3F40_0000);
      expect_op(0, 3'd6, 2'd2, 32'h0000_1111, 32'h3F40_0000, 1'b1, 1'b0, 32'h0000_1117);
      expect_op(2, 3'd5, 2'd1, 32'h2222_0000, 32'h3F40_0000, 1'b1, 1'b0, 32'h2222_0005);
      @(negedge clk);
      req_valid = '0;
      drain("t2_rr_drain", 200);

      // Fill ch1 while the core holds ready low; fifth request must wait.
      core_hold = 1'b1;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         load(1, 3'(k), 2'd0, 32'h10 * k, 32'h3F40_0000);
         expect_op(1, 3'(k), 2'd0, 32'h10 * k, 32'h3F40_0000, 1'b1, 1'b0,
                   core_fn(3'(k), 32'h10 * k, 32'h3F40_0000));
         @(negedge clk);
      end
      req_valid = '0;
      chk("t3_full_ready", 32'(req_ready[1]), 32'h0);
      load(1, 3'd7, 2'd3, 32'hABCD_0000, 32'h3F40_0000);
      expect_op(1, 3'd7, 2'd3, 32'hABCD_0000, 32'h3F40_0000, 1'b1, 1'b0, 32'hABCD_0007);
      repeat (3) @(negedge clk);
      chk("t3_held_ready", 32'(req_ready[1]), 32'h0);
      chk("t3_no_start", 32'(fpu_start), 32'h0);
      core_hold = 1'b0;
      n = 0;
      while (!req_ready[1] && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("t3_ready_back", 32'(req_ready[1]), 32'h1);
      @(negedge clk);
      req_valid = '0;
      drain("t3_drain", 300);

      // Table of single requests with varying core latency.
      for (int i = 0; i < 6; i++) begin
         core_lat = 2 + i;
         load(vecs[i].ch, vecs[i].op, vecs[i].rm, vecs[i].a, vecs[i].b);
         expect_op(vecs[i].ch, vecs[i].op, vecs[i].rm, vecs[i].a, vecs[i].b, 1'b1, 1'b0,
                   vecs[i].res);
         @(negedge clk);
         req_valid = '0;
         drain($sformatf("vec%0d_drain", i), 60);
      end

      // Core stalls past the watchdog; a queued request still goes out afterwards.
      core_lat = 30;
      chk("t4_terr_before", 32'(timeout_err), 32'h0);
      load(0, 3'd5, 2'd1, 32'h5555_0000, 32'h3F40_0000);
      expect_op(0, 3'd5, 2'd1, 32'h5555_0000, 32'h3F40_0000, 1'b1, 1'b1, 32'h0);
      @(negedge clk);
      req_valid = '0;
      load(2, 3'd6, 2'd0, 32'h6666_0000, 32'h3F40_0000);
      expect_op(2, 3'd6, 2'd0, 32'h6666_0000, 32'h3F40_0000, 1'b1, 1'b0, 32'h6666_0006);
      @(negedge clk);
      req_valid = '0;
      chk("t4_start", 32'(fpu_start), 32'h1);
      core_lat = 4;
      n = 0;
      while (rsp_valid == '0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("t4_abort_latency", 32'(n), 32'd9);
      @(negedge clk);
      chk("t4_terr_set", 32'(timeout_err), 32'h1);
      drain("t4_drain", 200);
      chk("t4_terr_sticky", 32'(timeout_err), 32'h1);

      // Reset two cycles into WAIT with three requests still queued.
      core_lat = 20;
      load(3, 3'd1, 2'd0, 32'hA000_0000, 32'h3F40_0000);
      expect_op(3, 3'd1, 2'd0, 32'hA000_0000, 32'h3F40_0000, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      load(3, 3'd2, 2'd0, 32'hB000_0000, 32'h3F40_0000);
      @(negedge clk);
      load(3, 3'd3, 2'd0, 32'hC000_0000, 32'h3F40_0000);
      @(negedge clk);
      load(3, 3'd4, 2'd0, 32'hD000_0000, 32'h3F40_0000);
      @(negedge clk);
      req_valid = '0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      rsp_q.delete();
      iss_q.delete();
      chk("t5_req_ready", 32'(req_ready), 32'hF);
      chk("t5_busy", 32'(busy), 32'h0);
      chk("t5_terr_clear", 32'(timeout_err), 32'h0);
      bad = 1'b0;
      repeat (25) begin
         @(negedge clk);
         if (fpu_start || busy) bad = 1'b1;
      end
      chk("t5_quiet", 32'(bad), 32'h0);

      // Ready arriving on the watchdog cycle completes; one cycle later aborts.
      core_lat = TMO;
      load(1, 3'd2, 2'd3, 32'h7777_0000, 32'h3F40_0000);
      expect_op(1, 3'd2, 2'd3, 32'h7777_0000, 32'h3F40_0000, 1'b1, 1'b0, 32'h7777_0002);
      @(negedge clk);
      req_valid = '0;
      drain("t6_edge_drain", 60);
      chk("t6_terr_clear", 32'(timeout_err), 32'h0);
      core_lat = TMO + 1;
      load(1, 3'd3, 2'd1, 32'h8888_0000, 32'h3F40_0000);
      expect_op(1, 3'd3, 2'd1, 32'h8888_0000, 32'h3F40_0000, 1'b1, 1'b1, 32'h0);
      @(negedge clk);
      req_valid = '0;
      drain("t6_abort_drain", 60);
      chk("t6_terr_set", 32'(timeout_err), 32'h1);
      repeat (10) @(negedge clk);
      chk("t6_late_ignored", 32'(busy), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
